// File: rtl/map_tile_store_if.sv
// Scanner lookup, cell-update handshake and level-ROM port of the map tile store.
// slave = the tile store; master = scanner, game logic and level ROM.
interface map_tile_store_if #(
    parameter int unsigned TILE_BITS  = 19,
    parameter int unsigned LEVEL_BITS = 3,
    parameter int unsigned ROM_AW     = 11
) ();
    logic [3:0]            grid_x;
    logic [3:0]            grid_y;
    logic [TILE_BITS-1:0]  tile_id;
    logic                  wr_req;
    logic [3:0]            wr_x;
    logic [3:0]            wr_y;
    logic [TILE_BITS-1:0]  wr_tile;
    logic                  wr_ack;
    logic                  load_req;
    logic [LEVEL_BITS-1:0] level;
    logic                  busy;
    logic                  load_done;
    logic [ROM_AW-1:0]     rom_addr;
    logic [TILE_BITS-1:0]  rom_data;

    modport slave (
        input  grid_x, grid_y, wr_req, wr_x, wr_y, wr_tile, load_req, level, rom_data,
        output tile_id, wr_ack, busy, load_done, rom_addr
    );

    modport master (
        output grid_x, grid_y, wr_req, wr_x, wr_y, wr_tile, load_req, level, rom_data,
        input  tile_id, wr_ack, busy, load_done, rom_addr
    );
endinterface

// File: rtl/map_tile_store.sv
// Tile-id array for the grid scanner: combinational lookups, single-cell
// writes over req/ack, and whole-level bulk load from the level ROM.
module map_tile_store #(
    parameter int unsigned MAP_WIDTH  = 12,
    parameter int unsigned MAP_HEIGHT = 12,
    parameter int unsigned TILE_BITS  = 19,
    parameter int unsigned LEVEL_BITS = 3,
    parameter int unsigned ROM_AW     = 11
) (
    input  logic             map_clk,
    input  logic             rstn,
    map_tile_store_if.slave  bus
);

    localparam int unsigned NCELLS  = MAP_WIDTH * MAP_HEIGHT;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CELL_AW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    typedef enum logic {IDLE, LOAD} state_e;

    state_e                state_q, state_d;
    logic [TILE_BITS-1:0]  cell_q [NCELLS];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  wr_ack_q, wr_ack_d;

    logic                  cell_we_c;
    logic [IDX_W-1:0]      cell_waddr_c;
    logic [TILE_BITS-1:0]  cell_wdata_c;
    logic                  last_c;
    logic [LEVEL_BITS-1:0] level_c;

    function automatic logic in_range(input logic [3:0] x, input logic [3:0] y);
        return (5'(x) < 5'(MAP_WIDTH)) && (5'(y) < 5'(MAP_HEIGHT));
    endfunction

    function automatic logic [IDX_W-1:0] flat_idx(input logic [3:0] x, input logic [3:0] y);
        return IDX_W'(y) * IDX_W'(MAP_WIDTH) + IDX_W'(x);
    endfunction

    assign level_c = bus.level;
    assign last_c  = (idx_q == IDX_W'(NCELLS - 1));

    // State register
    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.load_req) state_d = LOAD;
            LOAD: if (last_c)       state_d = IDLE;
        endcase
    end

    // Output / datapath next values; one cell write port shared by updates and loads
    always_comb begin
        idx_d        = idx_q;
        rom_addr_d   = rom_addr_q;
        busy_d       = busy_q;
        load_done_d  = 1'b0;
        wr_ack_d     = 1'b0;
        cell_we_c    = 1'b0;
        cell_waddr_c = '0;
        cell_wdata_c = '0;
        case (state_q)
            IDLE: begin
                // The cycle after an ack never acks, so a held request is not double-counted
                if (bus.wr_req && !wr_ack_q) begin
                    wr_ack_d = 1'b1;
                    if (in_range(bus.wr_x, bus.wr_y)) begin
                        cell_we_c    = 1'b1;
                        cell_waddr_c = flat_idx(bus.wr_x, bus.wr_y);
                        cell_wdata_c = bus.wr_tile;
                    end
                end
                if (bus.load_req) begin
                    rom_addr_d = ROM_AW'(level_c) * ROM_AW'(NCELLS);
                    idx_d      = '0;
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                cell_we_c    = 1'b1;
                cell_waddr_c = idx_q;
                cell_wdata_c = bus.rom_data;
                idx_d        = idx_q + IDX_W'(1);
                rom_addr_d   = rom_addr_q + ROM_AW'(1);
                if (last_c) begin
                    busy_d      = 1'b0;
                    load_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) begin
            idx_q       <= '0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    // Cell array; reset also wipes any partially loaded level
    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NCELLS); i++) cell_q[i] <= '0;
        end else if (cell_we_c) begin
            cell_q[CELL_AW'(cell_waddr_c)] <= cell_wdata_c;
        end
    end

    always_comb begin
        bus.tile_id = '0;
        if (in_range(bus.grid_x, bus.grid_y))
            bus.tile_id = cell_q[CELL_AW'(flat_idx(bus.grid_x, bus.grid_y))];
    end

    assign bus.wr_ack    = wr_ack_q;
    assign bus.busy      = busy_q;
    assign bus.load_done = load_done_q;
    assign bus.rom_addr  = rom_addr_q;

endmodule

// File: doc/map_tile_store.md
Name: map_tile_store

Overview:
- Map-side responder for the grid scanner. The scanner walks grid_x/grid_y once per map_clk period and expects the tile_id of that cell in return; this block holds the MAP_WIDTH x MAP_HEIGHT tile-id array and answers those lookups.
- Also accepts single-cell updates from game logic over a req/ack handshake.
- Also bulk-loads a whole level from the level ROM on request.

Parameters:
- MAP_WIDTH, 12, cells per row (1..16)
- MAP_HEIGHT, 12, cells per column (1..16)
- TILE_BITS, 19, tile_id width
- LEVEL_BITS, 3, level-select width
- ROM_AW, 11, level ROM address width; must hold 2^LEVEL_BITS*MAP_WIDTH*MAP_HEIGHT entries

Ports:
- map_clk  in  1  block clock
- rstn  in  1  reset, asynchronous, active-low
- grid_x  in  4  lookup column
- grid_y  in  4  lookup row
- tile_id  out  TILE_BITS  tile at (grid_x, grid_y)
- wr_req  in  1  cell-update request; held until wr_ack
- wr_x  in  4  update column
- wr_y  in  4  update row
- wr_tile  in  TILE_BITS  new tile id
- wr_ack  out  1  one-cycle acknowledge
- load_req  in  1  level-load request (level pulse)
- level  in  LEVEL_BITS  level to load, sampled with load_req
- busy  out  1  level load in progress
- load_done  out  1  one-cycle pulse at load completion
- rom_addr  out  ROM_AW  level ROM address
- rom_data  in  TILE_BITS  level ROM data, async read, valid in the same cycle as rom_addr

Behaviour:
- Reset (async, rstn low): all cells 0. tile_id 0, wr_ack 0, busy 0, load_done 0, rom_addr 0. FSM returns to IDLE. A load in progress is aborted; a partially loaded array is cleared to 0.
- Lookup:
  - tile_id is a combinational read of cell[grid_y*MAP_WIDTH+grid_x], so it is valid in the same map_clk period the scanner presents the coordinates.
  - If grid_x>=MAP_WIDTH or grid_y>=MAP_HEIGHT, tile_id = 0.
  - A cell written at edge e is visible on tile_id after edge e. Lookups continue during a load and return the current, possibly partial, contents.
- FSM states: IDLE, LOAD.
- IDLE:
  - On an edge with load_req=1: base <= level*MAP_WIDTH*MAP_HEIGHT (ROM_AW-bit multiply, no overflow by parameter rule), rom_addr <= base, idx <= 0, busy <= 1, go to LOAD.
  - On an edge with wr_req=1: if wr_x/wr_y are in range, cell <= wr_tile. In all cases wr_ack <= 1 for exactly one cycle, so out-of-range writes are acked and dropped.
  - Both requests on the same edge: the write is performed and acked, and the load is accepted; the load later overwrites the cell.
  - wr_ack stays 0 on the edge after an ack even if wr_req is still high. The next write is accepted on the following edge, so a continuous wr_req yields at most one ack per 2 cycles.
- LOAD:
  - Each edge: cell[idx] <= rom_data, idx++, rom_addr++. Cells fill in raster order (x fastest).
  - On the edge writing idx = N-1 (N = MAP_WIDTH*MAP_HEIGHT): busy <= 0, load_done <= 1 for one cycle, go to IDLE, rom_addr holds last+1.
  - busy is high for exactly N cycles.
  - wr_req during LOAD: not acked, stays pending, serviced on the first edge in IDLE.
  - load_req during LOAD: ignored, not queued.
- load_done and wr_ack are never asserted for more than one consecutive cycle each.
- Widths:
  - idx and rom_addr wrap modulo their widths; the parameter rule guarantees no wrap in legal use.
  - Cell index = y*MAP_WIDTH+x, computed at 8 bits.

Test Plan:
- Reset then sweep all 144 (x,y) with no writes -> tile_id 0 everywhere. grid_x=12, grid_y=0 -> tile_id 0.
- wr_req with (3,5,tile 0x00007) -> wr_ack high exactly 1 cycle. Next cycle (3,5) reads 7; (5,3) still 0. Write (15,15) -> acked, no cell changes.
- load_req with level=2, ROM returning data=addr -> rom_addr starts 288. busy high exactly 144 cycles, then load_done 1 cycle. Cell (x,y) reads 288+y*12+x.
- wr_req (0,0,0x1F) asserted 10 cycles into a load -> no ack while busy. Ack on first IDLE edge after load_done; (0,0) reads 0x1F.
- Second load_req mid-load -> ignored: busy still exactly 144 cycles, single load_done. load_req and wr_req on the same IDLE edge -> write acked, then overwritten by ROM data.
- rstn low at cycle 50 of a load -> busy, load_done, wr_ack 0 immediately; all cells read 0. A new load after release completes normally.
